mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Consumer of the EX/MEM pipeline register outputs in the 5-stage pipeline: runs the MEM stage and holds the MEM/WB pipeline register.
- Resolves branches from the EX_MEM branch, zero and adder-result signals.
- Accesses data memory over a req/ack handshake with a variable number of wait states.
- While an access is outstanding, drives mem_stall so upstream stages (PC, IF/ID, ID/EX, EX/MEM) hold.

Parameters:
TIMEOUT, 16, max WAIT cycles without dmem_ack before the access is aborted (>=1)
ERR_DATA, 32'h0000_0000, load data written back on timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
EX_MEM_adder_result  in  32  branch target from EX
EX_MEM_zero  in  1  ALU zero flag
EX_MEM_alu_result  in  32  ALU result / memory address
EX_MEM_read2_data  in  32  store data
EX_MEM_RD  in  5  destination register
EX_MEM_RegWrite  in  1  WB control
EX_MEM_MemtoReg  in  1  WB control
EX_MEM_MemWrite  in  1  store
EX_MEM_MemRead  in  1  load
EX_MEM_Branch  in  1  branch
dmem_req  out  1  memory request, registered
dmem_we  out  1  1=write, registered
dmem_addr  out  32  word address, registered
dmem_wdata  out  32  store data, registered
dmem_ack  in  1  memory completion, one cycle
dmem_rdata  in  32  load data, valid with dmem_ack
PCSrc  out  1  branch taken
branch_target  out  32  = EX_MEM_adder_result
mem_stall  out  1  upstream hold
mem_err  out  1  sticky timeout flag
MEM_WB_read_data  out  32  registered load data
MEM_WB_alu_result  out  32  registered ALU result
MEM_WB_RD  out  5  registered destination
MEM_WB_RegWrite  out  1  registered
MEM_WB_MemtoReg  out  1  registered

Behaviour:
- Reset: all registered outputs 0; state IDLE; timeout counter 0; mem_err 0.
- memop = EX_MEM_MemRead | EX_MEM_MemWrite.
- FSM states: IDLE, WAIT.
  - IDLE & !memop: no stall. MEM/WB captures the EX_MEM fields next edge; MEM_WB_read_data = 0. Latency 1 cycle.
  - IDLE & memop: mem_stall = 1 (combinational). Next edge: dmem_req=1, dmem_we=EX_MEM_MemWrite, dmem_addr=alu_result, dmem_wdata=read2_data, counter=0, state goes to WAIT. MEM/WB loads a bubble (RegWrite=0, MemtoReg=0; other fields don't-care but held).
  - WAIT & !dmem_ack: mem_stall=1; counter++. MEM/WB holds the bubble.
  - WAIT & dmem_ack: mem_stall=0 in that same cycle. Next edge: MEM/WB captures EX_MEM fields, with read_data = dmem_rdata if MemRead, else 0. dmem_req=0; state goes to IDLE. Upstream advances on the same edge.
  - WAIT & counter==TIMEOUT-1 & !dmem_ack: treated as completion with read_data=ERR_DATA. mem_err set (sticky until rst). Request dropped.
- Minimum memory-op occupancy: 2 cycles (one stall cycle).
- MemRead & MemWrite both set: the write is performed; MEM_WB_read_data = 0; RegWrite passes through unchanged.
- dmem_ack outside WAIT is ignored.
- dmem_req/addr/we/wdata stay stable throughout WAIT.
- PCSrc = EX_MEM_Branch & EX_MEM_zero, combinational, forced 0 while mem_stall=1. branch_target is combinational passthrough.
- rst during WAIT: request dropped immediately on that edge; state IDLE; a late ack is ignored.
- No arithmetic beyond the counter, which is sized $clog2(TIMEOUT+1) and saturates.

Decomposition:
- cpu_pkg holds: state enum {IDLE, WAIT}, XLEN=32, REG_ADDR_W=5.
- Sub-module mem_wb_reg: plain MEM/WB register with load/bubble inputs, synchronous reset.
- FSM, handshake and branch logic live in mem_wb_stage.

Test Plan:
- ALU passthrough: alu_result=0x1234, RD=5, RegWrite=1, no memop -> next edge MEM_WB_alu_result=0x1234, MEM_WB_RD=5, RegWrite=1; mem_stall never high.
- Load, ack on 3rd WAIT cycle: addr=0x40, rdata=0xCAFEF00D -> dmem_req high 3 cycles with addr 0x40 and we=0. mem_stall high 3 cycles. MEM_WB_read_data=0xCAFEF00D and MemtoReg=1 on the edge after ack; bubble (RegWrite=0) before that.
- Store, ack in 1st WAIT cycle: addr=0x80, wdata=0xA5A5A5A5 -> dmem_we=1, one stall cycle, MEM_WB_RegWrite=0, read_data=0.
- Branch: Branch=1, zero=1, adder=0x100 -> PCSrc=1, branch_target=0x100 in the same cycle. With zero=0 -> PCSrc=0.
- Timeout with TIMEOUT=8 and no ack: load -> req drops after 8 WAIT cycles, mem_err=1 and stays 1, MEM_WB_read_data=ERR_DATA, stall released.
- rst asserted in 2nd WAIT cycle, then ack pulsed -> dmem_req=0, state IDLE, all outputs 0, ack ignored, no MEM/WB update.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU pipeline stages.
// No logic: type and width definitions only.
// No flow control: consumers apply their own handshakes.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // MEM-stage access sequencer: IDLE issues a request, WAIT holds it until ack or timeout
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures writeback fields or inserts a bubble.
// Latency: 1 cycle from load_i/bubble_i to outputs.
// Backpressure: neither load nor bubble asserted means the contents are held.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [XLEN-1:0]       read_data_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    output logic [XLEN-1:0]       read_data_o,
    output logic [XLEN-1:0]       alu_result_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o
);

    // Bubble clears only the write-enabling controls; data fields keep their old values
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_o  <= '0;
            alu_result_o <= '0;
            rd_o         <= '0;
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
        end else if (bubble_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
        end else if (load_i) begin
            read_data_o  <= read_data_i;
            alu_result_o <= alu_result_i;
            rd_o         <= rd_i;
            reg_write_o  <= reg_write_i;
            mem_to_reg_o <= mem_to_reg_i;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: branch resolve, data-memory req/ack access with timeout, MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops take 2+ cycles (issue, then wait for ack).
// Backpressure: mem_stall holds upstream from issue until ack or timeout completes the access.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int              TIMEOUT  = 16,
    parameter logic [XLEN-1:0] ERR_DATA = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       EX_MEM_adder_result,
    input  logic                  EX_MEM_zero,
    input  logic [XLEN-1:0]       EX_MEM_alu_result,
    input  logic [XLEN-1:0]       EX_MEM_read2_data,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RD,
    input  logic                  EX_MEM_RegWrite,
    input  logic                  EX_MEM_MemtoReg,
    input  logic                  EX_MEM_MemWrite,
    input  logic                  EX_MEM_MemRead,
    input  logic                  EX_MEM_Branch,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  PCSrc,
    output logic [XLEN-1:0]       branch_target,
    output logic                  mem_stall,
    output logic                  mem_err,
    output logic [XLEN-1:0]       MEM_WB_read_data,
    output logic [XLEN-1:0]       MEM_WB_alu_result,
    output logic [REG_ADDR_W-1:0] MEM_WB_RD,
    output logic                  MEM_WB_RegWrite,
    output logic                  MEM_WB_MemtoReg
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             memop;
    logic             timeout_hit;
    logic             done;
    logic             wb_bubble;
    logic             wb_load;
    logic [XLEN-1:0]  wb_read_data_d;

    assign memop       = EX_MEM_MemRead | EX_MEM_MemWrite;
    // A timeout on the final wait cycle completes the access exactly like an ack would
    assign timeout_hit = (state_q == WAIT) && !dmem_ack && (cnt_q == CNT_LAST);
    assign done        = (state_q == WAIT) && (dmem_ack || timeout_hit);
    assign mem_stall   = ((state_q == IDLE) && memop) || ((state_q == WAIT) && !done);
    assign wb_bubble   = (state_q == IDLE) && memop;
    assign wb_load     = !mem_stall;

    assign PCSrc         = EX_MEM_Branch & EX_MEM_zero & ~mem_stall;
    assign branch_target = EX_MEM_adder_result;

    // Load data only for a pure read; a simultaneous read+write is treated as a store
    always_comb begin
        wb_read_data_d = '0;
        if (state_q == WAIT) begin
            if (timeout_hit) begin
                wb_read_data_d = ERR_DATA;
            end else if (dmem_ack && EX_MEM_MemRead && !EX_MEM_MemWrite) begin
                wb_read_data_d = dmem_rdata;
            end
        end
    end

    // Access sequencer: issue registered request, hold it stable, drop it on ack/timeout/reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memop) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= EX_MEM_MemWrite;
                        dmem_addr  <= EX_MEM_alu_result;
                        dmem_wdata <= EX_MEM_read2_data;
                        cnt_q      <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (done) begin
                        dmem_req <= 1'b0;
                        state_q  <= IDLE;
                        if (timeout_hit) begin
                            mem_err <= 1'b1;
                        end
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .load_i       (wb_load),
        .bubble_i     (wb_bubble),
        .read_data_i  (wb_read_data_d),
        .alu_result_i (EX_MEM_alu_result),
        .rd_i         (EX_MEM_RD),
        .reg_write_i  (EX_MEM_RegWrite),
        .mem_to_reg_i (EX_MEM_MemtoReg),
        .read_data_o  (MEM_WB_read_data),
        .alu_result_o (MEM_WB_alu_result),
        .rd_o         (MEM_WB_RD),
        .reg_write_o  (MEM_WB_RegWrite),
        .mem_to_reg_o (MEM_WB_MemtoReg)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with writeback and request scoreboards.
// Stimulus pushes expected MEM/WB captures and memory requests; monitors pop and compare.
// Each memory op is bounded by a cycle budget; a global watchdog bounds the whole run.
module tb_mem_wb_stage;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] EX_MEM_adder_result = '0;
    logic        EX_MEM_zero = 1'b0;
    logic [31:0] EX_MEM_alu_result = '0;
    logic [31:0] EX_MEM_read2_data = '0;
    logic [4:0]  EX_MEM_RD = '0;
    logic        EX_MEM_RegWrite = 1'b0;
    logic        EX_MEM_MemtoReg = 1'b0;
    logic        EX_MEM_MemWrite = 1'b0;
    logic        EX_MEM_MemRead = 1'b0;
    logic        EX_MEM_Branch = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        mem_stall, mem_err;
    logic [31:0] MEM_WB_read_data, MEM_WB_alu_result;
    logic [4:0]  MEM_WB_RD;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } req_exp_t;

    wb_exp_t  sbq[$];
    req_exp_t reqq[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic        mon_adv;
    logic        req_prev = 1'b0;
    req_exp_t    req_cur;
    wb_exp_t     wb_cur;

    mem_wb_stage #(.TIMEOUT(8), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_adder_result(EX_MEM_adder_result), .EX_MEM_zero(EX_MEM_zero),
        .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_read2_data(EX_MEM_read2_data),
        .EX_MEM_RD(EX_MEM_RD), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_Branch(EX_MEM_Branch),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .PCSrc(PCSrc), .branch_target(branch_target), .mem_stall(mem_stall),
        .mem_err(mem_err), .MEM_WB_read_data(MEM_WB_read_data),
        .MEM_WB_alu_result(MEM_WB_alu_result), .MEM_WB_RD(MEM_WB_RD),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] adder,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic mw, input logic mr, input logic br, input logic z);
        EX_MEM_alu_result   = alu;
        EX_MEM_read2_data   = wd;
        EX_MEM_adder_result = adder;
        EX_MEM_RD           = rd;
        EX_MEM_RegWrite     = rw;
        EX_MEM_MemtoReg     = m2r;
        EX_MEM_MemWrite     = mw;
        EX_MEM_MemRead      = mr;
        EX_MEM_Branch       = br;
        EX_MEM_zero         = z;
    endtask

    // One non-memory cycle: expect an immediate MEM/WB capture and no stall
    task automatic alu_cycle(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        wb_exp_t e;
        drive(alu, 32'h0, 32'h0, rd, rw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e.alu = alu; e.rdata = 32'h0; e.rd = rd; e.rw = rw; e.m2r = 1'b0;
        sbq.push_back(e);
        #1;
        chk("alu_no_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
    endtask

    // Memory op: ack_at is the WAIT-cycle index carrying the ack (-1 = never ack)
    task automatic memop(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic mw, input logic mr,
                         input logic br, input int ack_at, input logic [31:0] rdata,
                         input logic [31:0] exp_rdata, output int stalls, output int reqs);
        req_exp_t r;
        wb_exp_t  e;
        bit       fin = 0;
        stalls = 0;
        reqs   = 0;
        drive(addr, wd, 32'h0, rd, rw, m2r, mw, mr, br, br);
        r.addr = addr; r.wdata = wd; r.we = mw;
        reqq.push_back(r);
        #1;
        chk("issue_stall", mem_stall, 1'b1);
        chk("pcsrc_gated", PCSrc, 1'b0);
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            chk("bubble_rw", MEM_WB_RegWrite, 1'b0);
            chk("bubble_m2r", MEM_WB_MemtoReg, 1'b0);
            if (dmem_req) reqs++;
            dmem_ack   = (k == ack_at);
            dmem_rdata = rdata;
            #1;
            if (!mem_stall) begin
                e.alu = addr; e.rdata = exp_rdata; e.rd = rd; e.rw = rw; e.m2r = m2r;
                sbq.push_back(e);
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                chk("req_dropped", dmem_req, 1'b0);
                fin = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL memop_timeout_budget: access to %h never completed", addr);
        end
    endtask

    // Writeback monitor: the stage advances on every edge where mem_stall was low
    initial begin
        forever begin
            @(negedge clk);
            mon_adv = !mem_stall && !rst;
            @(posedge clk); #2;
            if (mon_adv) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL wb_unexpected: capture alu=%h with empty scoreboard", MEM_WB_alu_result);
                end else begin
                    wb_cur = sbq.pop_front();
                    chk("wb_alu", MEM_WB_alu_result, wb_cur.alu);
                    chk("wb_rdata", MEM_WB_read_data, wb_cur.rdata);
                    chk("wb_rd", {27'h0, MEM_WB_RD}, {27'h0, wb_cur.rd});
                    chk("wb_rw", MEM_WB_RegWrite, wb_cur.rw);
                    chk("wb_m2r", MEM_WB_MemtoReg, wb_cur.m2r);
                end
            end
        end
    end

    // Request monitor: compare on request rise, then require stability while held
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_req && !req_prev) begin
                if (reqq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL req_unexpected: addr=%h", dmem_addr);
                end else begin
                    req_cur = reqq.pop_front();
                    chk("req_addr", dmem_addr, req_cur.addr);
                    chk("req_we", dmem_we, req_cur.we);
                    chk("req_wdata", dmem_wdata, req_cur.wdata);
                end
            end else if (dmem_req) begin
                chk("req_addr_stable", dmem_addr, req_cur.addr);
                chk("req_we_stable", dmem_we, req_cur.we);
            end
            req_prev = dmem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, rq;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_err", mem_err, 1'b0);
        chk("rst_wb_alu", MEM_WB_alu_result, 32'h0);
        chk("rst_wb_rw", MEM_WB_RegWrite, 1'b0);
        rst = 1'b0;

        // ALU passthrough
        alu_cycle(32'h0000_1234, 5'd5, 1'b1);
        alu_cycle(32'h0000_0000, 5'd0, 1'b0);

        // Load, ack on third WAIT cycle
        memop(32'h40, 32'h55, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, st, rq);
        chk("load_stall_cycles", st, 3);
        chk("load_req_cycles", rq, 3);
        alu_cycle(32'h0, 5'd0, 1'b0);
        chk("err_still_clear", mem_err, 1'b0);

        // Store, ack in first WAIT cycle, branch gated during stall
        memop(32'h80, 32'hA5A5_A5A5, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h1357_9BDF, 32'h0, st, rq);
        chk("store_stall_cycles", st, 1);
        chk("store_req_cycles", rq, 1);

        // Read+write together: store wins, read data zero, RegWrite passes through
        memop(32'hC0, 32'h0F0F_0F0F, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h7777_7777, 32'h0, st, rq);
        chk("rw_stall_cycles", st, 2);

        // Branch resolution
        drive(32'h0, 32'h0, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        sbq.push_back('{alu: 32'h0, rdata: 32'h0, rd: 5'd0, rw: 1'b0, m2r: 1'b0});
        #1;
        chk("branch_taken", PCSrc, 1'b1);
        chk("branch_target", branch_target, 32'h100);
        @(posedge clk); #1;
        drive(32'h0, 32'h0, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        sbq.push_back('{alu: 32'h0, rdata: 32'h0, rd: 5'd0, rw: 1'b0, m2r: 1'b0});
        #1;
        chk("branch_not_taken", PCSrc, 1'b0);
        @(posedge clk); #1;

        // Timeout: no ack, completes after 8 WAIT cycles with ERR data
        memop(32'h1F0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, 32'h0, ERR, st, rq);
        chk("timeout_req_cycles", rq, 8);
        chk("timeout_stall_cycles", st, 8);
        chk("timeout_err", mem_err, 1'b1);
        alu_cycle(32'h0, 5'd0, 1'b0);
        alu_cycle(32'h0, 5'd0, 1'b0);
        chk("err_sticky", mem_err, 1'b1);

        // Reset during second WAIT cycle, then a late ack
        drive(32'h200, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        reqq.push_back('{addr: 32'h200, wdata: 32'h0, we: 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_req", dmem_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait_req", dmem_req, 1'b0);
        chk("rst_wait_err", mem_err, 1'b0);
        chk("rst_wait_wb_rw", MEM_WB_RegWrite, 1'b0);
        chk("rst_wait_wb_alu", MEM_WB_alu_result, 32'h0);
        chk("rst_wait_wb_rdata", MEM_WB_read_data, 32'h0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        sbq.push_back('{alu: 32'h0, rdata: 32'h0, rd: 5'd0, rw: 1'b0, m2r: 1'b0});
        #1;
        chk("late_ack_no_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", dmem_req, 1'b0);
        #2;
        chk("wb_queue_drained", sbq.size(), 0);
        chk("req_queue_drained", reqq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
